// File: rtl/io_cfg_loader.sv
// Serial configuration loader: shifts a CW-bit frame LSB first, rejects frames with
// contended input slices, and commits the rest to c. Optional parity: IO_CFG_PARITY_EN.
module io_cfg_loader #(
  parameter int W          = 12,
  parameter int EXTDATAIN  = 3,
  parameter int EXTDATAOUT = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_start,
  input  logic                              cfg_valid,
  input  logic                              cfg_bit,
  output logic                              cfg_ready,
  output logic [W*(EXTDATAIN+EXTDATAOUT)-1:0] c,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int CW    = W * (EXTDATAIN + EXTDATAOUT);
  localparam int CNT_W = $clog2(CW + 1);

`ifdef IO_CFG_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CW-1:0]    r_shadow;
  logic [CW-1:0]    r_c;
  logic             r_done;
  logic             r_err;
  logic             w_restart;
  logic             w_accept;
  logic             w_contend;
  logic             w_seen;
  logic             w_reject;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    busy        = 1'b0;
    w_restart   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_start) begin
          w_restart   = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        // A restart wins over a bit presented on the same edge.
        if (cfg_start) begin
          w_restart = 1'b1;
        end else if (cfg_valid) begin
          w_accept = 1'b1;
          if (r_cnt == CNT_W'(CW - 1)) begin
`ifdef IO_CFG_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = CHECK;
`endif
          end
        end
      end
`ifdef IO_CFG_PARITY_EN
      PARITY: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (cfg_start) begin
          w_restart   = 1'b1;
          w_state_nxt = SHIFT;
        end else if (cfg_valid) begin
          w_state_nxt = CHECK;
        end
      end
`endif
      CHECK: begin
        busy        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Contention: more than one input slice driving the same data bit j.
  always_comb begin
    w_contend = 1'b0;
    w_seen    = 1'b0;
    for (int j = 0; j < W; j++) begin
      w_seen = 1'b0;
      for (int i = 0; i < EXTDATAIN; i++) begin
        if (r_shadow[j + i*W]) begin
          if (w_seen) w_contend = 1'b1;
          w_seen = 1'b1;
        end
      end
    end
  end

`ifdef IO_CFG_PARITY_EN
  logic r_par;

  always_ff @(posedge clk) begin
    if (rst)                                          r_par <= 1'b0;
    else if (w_restart)                               r_par <= 1'b0;
    else if (cfg_ready && cfg_valid && !cfg_start)    r_par <= r_par ^ cfg_bit;
  end

  assign w_reject = w_contend | r_par;
`else
  assign w_reject = w_contend;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
      r_c      <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_restart) begin
        r_cnt    <= '0;
        r_shadow <= '0;
      end else if (w_accept) begin
        r_shadow[r_cnt] <= cfg_bit;
        r_cnt           <= r_cnt + 1'b1;
      end
      if (r_state == CHECK) begin
        r_cnt <= '0;
        if (w_reject) begin
          r_err <= 1'b1;
        end else begin
          r_c    <= r_shadow;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign c    = r_c;
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_io_cfg_loader.sv
// Scoreboard bench for io_cfg_loader at default parameters; honours IO_CFG_PARITY_EN.
module tb_io_cfg_loader;

  localparam int W  = 12;
  localparam int EI = 3;
  localparam int EO = 2;
  localparam int CW = W * (EI + EO);
`ifdef IO_CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, cfg_start, cfg_valid, cfg_bit;
  logic          cfg_ready, busy, done, err;
  logic [CW-1:0] c;

  io_cfg_loader #(.W(W), .EXTDATAIN(EI), .EXTDATAOUT(EO)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_ready(cfg_ready), .c(c), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    kind;   // {done, err}
    logic [CW-1:0] cv;
    int            cy;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [CW-1:0] c_model;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : mon
    exp_t e;
    if (done === 1'b1 || err === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_pulse", {62'd0, done, err}, 64'd0);
      end else begin
        e = q.pop_front();
        chk("kind", {62'd0, done, err}, {62'd0, e.kind});
        chk("c_out", {4'd0, c}, {4'd0, e.cv});
        chk("latency", 64'(cyc), 64'(e.cy));
        chk("busy_post", {63'd0, busy}, 64'd0);
      end
    end
  end

  function automatic bit contended(input logic [CW-1:0] f);
    int n;
    for (int j = 0; j < W; j++) begin
      n = 0;
      for (int i = 0; i < EI; i++) n += int'(f[j + i*W]);
      if (n > 1) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic send_bit(input logic b, input bit gap);
    if (gap) begin
      cfg_valid = 1'b0;
      @(posedge clk); #1;
      chk("ready_stall", {63'd0, cfg_ready}, 64'd1);
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
  endtask

  // cfg_valid/cfg_bit are held high with the start so a stray bit would corrupt the frame.
  task automatic start_frame();
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    chk("busy_start", {63'd0, busy}, 64'd1);
    chk("ready_start", {63'd0, cfg_ready}, 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain", 64'(q.size()), 64'd0);
    q.delete();
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input logic [CW-1:0] f, input bit gap, input bit flip);
    exp_t e;
    bit   bad;
    start_frame();
    for (int n = 0; n < CW; n++) send_bit(f[n], gap);
    if (PAR_EN) send_bit((^f) ^ flip, gap);
    bad = contended(f) || (PAR_EN && flip);
    e.kind = bad ? 2'b01 : 2'b10;
    if (!bad) c_model = f;
    e.cv = c_model;
    e.cy = cyc + 1;
    q.push_back(e);
    wait_drain();
  endtask

  function automatic logic [CW-1:0] legal_frame();
    logic [CW-1:0] f;
    int            k;
    f = '0;
    for (int j = 0; j < W; j++) begin
      k = int'($urandom_range(0, EI));
      if (k < EI) f[j + k*W] = 1'b1;
    end
    for (int n = EI*W; n < CW; n++) f[n] = 1'($urandom);
    return f;
  endfunction

  initial begin
    logic [CW-1:0] f;
    rst = 1'b1; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
    c_model = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_c", {4'd0, c}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, cfg_ready}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    f = '0; f[0] = 1'b1; f[37] = 1'b1;
    send_frame(f, 1'b0, 1'b0);

    f = '0; f[0] = 1'b1; f[12] = 1'b1;
    send_frame(f, 1'b0, 1'b0);

    for (int t = 0; t < 3; t++) send_frame(legal_frame(), 1'b0, 1'b0);
    f = '0; f[11] = 1'b1; f[35] = 1'b1; f[50] = 1'b1;
    send_frame(f, 1'b0, 1'b0);

    // Partial frame then restart mid-SHIFT
    start_frame();
    for (int n = 0; n < 30; n++) send_bit(1'b1, 1'b0);
    chk("partial_c", {4'd0, c}, {4'd0, c_model});
    chk("partial_busy", {63'd0, busy}, 64'd1);
    f = '0; f[5] = 1'b1;
    send_frame(f, 1'b0, 1'b0);

    f = '0; f[0] = 1'b1; f[37] = 1'b1;
    send_frame(f, 1'b1, 1'b0);

    if (PAR_EN) begin
      f = '0; f[5] = 1'b1;
      send_frame(f, 1'b0, 1'b0);
      f = '0; f[7] = 1'b1;
      send_frame(f, 1'b0, 1'b1);
    end

    // Reset mid-frame
    start_frame();
    for (int n = 0; n < 20; n++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    c_model = '0;
    chk("midrst_c", {4'd0, c}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_ready", {63'd0, cfg_ready}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_err", {63'd0, err}, 64'd0);

    f = '0; f[59] = 1'b1; f[3] = 1'b1;
    send_frame(f, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
